// File: rtl/traffic_light_pkg.sv
// Shared encodings, phase/state enums and fault codes for the traffic light monitor.
package traffic_light_pkg;

   localparam logic [1:0] LightRed     = 2'b00;
   localparam logic [1:0] LightYellow  = 2'b01;
   localparam logic [1:0] LightGreen   = 2'b10;
   localparam logic [1:0] LightIllegal = 2'b11;

   typedef enum logic [1:0] {
      PhNsGreen  = 2'd0,
      PhNsYellow = 2'd1,
      PhEwGreen  = 2'd2,
      PhEwYellow = 2'd3
   } phase_e;

   typedef enum logic [1:0] {
      StSync,
      StRun,
      StHold
   } mon_state_e;

   localparam logic [2:0] FaultNone        = 3'd0;
   localparam logic [2:0] FaultConflict    = 3'd1;
   localparam logic [2:0] FaultIllegal     = 3'd2;
   localparam logic [2:0] FaultBadTrans    = 3'd3;
   localparam logic [2:0] FaultStuck       = 3'd4;
   localparam logic [2:0] FaultShortYellow = 3'd5;
   localparam logic [2:0] FaultEmergency   = 3'd6;
   localparam logic [2:0] FaultRelease     = 3'd7;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PhNsGreen:  next_phase = PhNsYellow;
         PhNsYellow: next_phase = PhEwGreen;
         PhEwGreen:  next_phase = PhEwYellow;
         default:    next_phase = PhNsGreen;
      endcase
   endfunction

   function automatic logic is_yellow(input phase_e p);
      return (p == PhNsYellow) || (p == PhEwYellow);
   endfunction

endpackage

// File: rtl/traffic_light_monitor_decode.sv
// Combinational classifier of one NS/EW light sample into phase / all-red / conflict / illegal.
module tl_pattern_decode
   import traffic_light_pkg::*;
(
   input  logic [1:0] ns_light,
   input  logic [1:0] ew_light,
   output logic [1:0] phase,
   output logic       legal,
   output logic       all_red,
   output logic       conflict,
   output logic       illegal
);

   always_comb begin
      illegal  = (ns_light == LightIllegal) || (ew_light == LightIllegal);
      all_red  = !illegal && (ns_light == LightRed) && (ew_light == LightRed);
      conflict = !illegal && (ns_light != LightRed) && (ew_light != LightRed);
      legal    = !illegal && !all_red && !conflict;
      // Only meaningful when legal: exactly one side is red.
      if (ns_light == LightRed) begin
         phase = (ew_light == LightYellow) ? PhEwYellow : PhEwGreen;
      end else begin
         phase = (ns_light == LightYellow) ? PhNsYellow : PhNsGreen;
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of a traffic-light controller's outputs: tracks phase sequence and dwell,
// emergency response, and latches the first violation as a sticky fault code.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int unsigned GREEN_MAX  = 12,
   parameter int unsigned YELLOW_MIN = 2,
   parameter int unsigned YELLOW_MAX = 4,
   parameter int unsigned EMERG_LAT  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       emergency,
   input  logic [1:0] ns_light,
   input  logic [1:0] ew_light,
   input  logic       clear,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] phase,
   output logic       phase_valid,
   output logic [7:0] fault_count
);

   localparam int unsigned DwellW = $clog2(GREEN_MAX + 2);
   localparam int unsigned EmergW = $clog2(EMERG_LAT + 2);
   localparam logic [DwellW-1:0] DwellSat  = DwellW'(GREEN_MAX + 1);
   localparam logic [DwellW-1:0] DwellOne  = DwellW'(1);
   localparam logic [DwellW-1:0] GreenMax  = DwellW'(GREEN_MAX);
   localparam logic [DwellW-1:0] YellowMax = DwellW'(YELLOW_MAX);
   localparam logic [DwellW-1:0] YellowMin = DwellW'(YELLOW_MIN);
   localparam logic [EmergW-1:0] EmergSat  = EmergW'(EMERG_LAT + 1);
   localparam logic [EmergW-1:0] EmergLat  = EmergW'(EMERG_LAT);

   logic [1:0] smp_phase_raw;
   logic       smp_legal, smp_all_red, smp_conflict, smp_illegal;
   phase_e     smp_phase;

   mon_state_e        state_q, state_d;
   phase_e            phase_q, phase_d;
   logic [DwellW-1:0] dwell_q, dwell_d, dwell_inc;
   logic [EmergW-1:0] emerg_cnt_q, emerg_cnt_d, rel_cnt_q, rel_cnt_d;
   logic              armed_q, armed_d;
   logic              chk_trans, chk_short, chk_stuck, chk_emerg, chk_release, any_fire;
   logic [2:0]        new_code;

   tl_pattern_decode u_decode (
      .ns_light (ns_light),
      .ew_light (ew_light),
      .phase    (smp_phase_raw),
      .legal    (smp_legal),
      .all_red  (smp_all_red),
      .conflict (smp_conflict),
      .illegal  (smp_illegal)
   );

   assign smp_phase = phase_e'(smp_phase_raw);
   assign phase     = phase_q;

   always_comb begin
      emerg_cnt_d = '0;
      if (emergency && !smp_all_red) begin
         emerg_cnt_d = (emerg_cnt_q == EmergSat) ? EmergSat : emerg_cnt_q + 1'b1;
      end
      // Release timer only runs once an emergency has been seen, so a power-up all-red is benign.
      armed_d   = armed_q | emergency;
      rel_cnt_d = '0;
      if (!emergency && armed_q) begin
         rel_cnt_d = (rel_cnt_q == EmergSat) ? EmergSat : rel_cnt_q + 1'b1;
      end

      dwell_inc = (dwell_q == DwellSat) ? DwellSat : dwell_q + 1'b1;
      state_d   = state_q;
      phase_d   = phase_q;
      dwell_d   = dwell_q;
      chk_trans = 1'b0;
      chk_short = 1'b0;
      chk_stuck = 1'b0;

      unique case (state_q)
         StSync: begin
            if (smp_legal) begin
               state_d = StRun;
               phase_d = smp_phase;
               dwell_d = DwellOne;
            end
         end
         StRun, StHold: begin
            if (smp_all_red) begin
               state_d = StHold;
            end else if (smp_legal) begin
               state_d = StRun;
               phase_d = smp_phase;
               if (smp_phase == phase_q) begin
                  dwell_d   = dwell_inc;
                  chk_stuck = is_yellow(phase_q) ? (dwell_inc > YellowMax)
                                                 : (dwell_inc > GreenMax);
               end else begin
                  dwell_d = DwellOne;
                  if (smp_phase == next_phase(phase_q)) begin
                     chk_short = is_yellow(phase_q) && (dwell_q < YellowMin);
                  end else begin
                     chk_trans = 1'b1;
                  end
               end
            end
         end
         default: state_d = StSync;
      endcase

      chk_emerg   = emerg_cnt_d > EmergLat;
      chk_release = (state_q != StSync) && smp_all_red && !emergency && armed_q &&
                    (rel_cnt_d > EmergLat);

      any_fire = smp_illegal | smp_conflict | chk_emerg | chk_release |
                 chk_trans | chk_short | chk_stuck;
      if (smp_illegal)       new_code = FaultIllegal;
      else if (smp_conflict) new_code = FaultConflict;
      else if (chk_emerg)    new_code = FaultEmergency;
      else if (chk_release)  new_code = FaultRelease;
      else if (chk_trans)    new_code = FaultBadTrans;
      else if (chk_short)    new_code = FaultShortYellow;
      else if (chk_stuck)    new_code = FaultStuck;
      else                   new_code = FaultNone;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StSync;
         phase_q     <= PhNsGreen;
         dwell_q     <= '0;
         emerg_cnt_q <= '0;
         rel_cnt_q   <= '0;
         armed_q     <= 1'b0;
         phase_valid <= 1'b0;
         fault       <= 1'b0;
         fault_code  <= FaultNone;
         fault_count <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         dwell_q     <= dwell_d;
         emerg_cnt_q <= emerg_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         armed_q     <= armed_d;
         phase_valid <= (state_d != StSync);
         // clear yields to a same-edge violation, which then overwrites the latched code.
         if (any_fire && (!fault || clear)) begin
            fault      <= 1'b1;
            fault_code <= new_code;
         end else if (clear) begin
            fault      <= 1'b0;
            fault_code <= FaultNone;
         end
         if (any_fire && (fault_count != 8'hFF)) begin
            fault_count <= fault_count + 8'd1;
         end
      end
   end

endmodule
